// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory over req/ack,
// buffers one instruction under decode backpressure, and reports sticky fetch errors.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        PcReSet,
    input  logic [31:0] PC,
    input  logic        flush,
    input  logic        id_ready,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        pc_stall,
    output logic        fetch_err
);

    localparam int CW = $clog2(IMEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, ERR} state_t;

    state_t          state, state_nxt;
    logic            req_nxt, valid_nxt, drop, drop_nxt, err_nxt;
    logic [31:0]     addr_nxt, instr_nxt, pc_nxt;
    logic            skid_valid, skid_valid_nxt;
    logic [31:0]     skid_instr, skid_instr_nxt, skid_pc, skid_pc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            load_id;
    logic [31:0]     ld_instr, ld_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            drop       <= 1'b0;
            cnt        <= '0;
            fetch_err  <= 1'b0;
        end else begin
            imem_req   <= req_nxt;
            imem_addr  <= addr_nxt;
            id_valid   <= valid_nxt;
            id_instr   <= instr_nxt;
            id_pc      <= pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            drop       <= drop_nxt;
            cnt        <= cnt_nxt;
            fetch_err  <= err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        req_nxt        = imem_req;
        addr_nxt       = imem_addr;
        drop_nxt       = drop;
        cnt_nxt        = cnt;
        err_nxt        = fetch_err;
        skid_valid_nxt = skid_valid;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        load_id        = 1'b0;
        ld_instr       = '0;
        ld_pc          = '0;

        case (state)
            IDLE: begin
                // The PC is being redirected during a flush, so no fetch starts from it.
                if (flush) begin
                    state_nxt = IDLE;
                end else if (PC[1:0] != 2'b00) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end else begin
                    addr_nxt  = PC;
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    drop_nxt  = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                    if (drop || flush) begin
                        state_nxt = IDLE;
                    end else if (!id_valid || id_ready) begin
                        load_id  = 1'b1;
                        ld_instr = imem_rdata;
                        ld_pc    = imem_addr;
                    end else begin
                        skid_valid_nxt = 1'b1;
                        skid_instr_nxt = imem_rdata;
                        skid_pc_nxt    = imem_addr;
                        state_nxt      = HOLD;
                    end
                end else begin
                    if (flush) drop_nxt = 1'b1;
                    if (cnt == CW'(IMEM_TIMEOUT - 1)) begin
                        state_nxt = ERR;
                        req_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    skid_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end else if (id_ready) begin
                    load_id        = 1'b1;
                    ld_instr       = skid_instr;
                    ld_pc          = skid_pc;
                    skid_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            ERR: begin
                req_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output slot: flush beats a new load, a load beats a plain drain.
    always_comb begin
        valid_nxt = id_valid;
        instr_nxt = id_instr;
        pc_nxt    = id_pc;
        if (flush) begin
            valid_nxt = 1'b0;
        end else if (load_id) begin
            valid_nxt = 1'b1;
            instr_nxt = ld_instr;
            pc_nxt    = ld_pc;
        end else if (id_ready) begin
            valid_nxt = 1'b0;
        end
    end

    assign pc_stall    = !((state == WAIT && imem_ack && !drop && !flush) ||
                           (flush && state != ERR));
    assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected deliveries go into a queue,
// a negedge monitor pops and compares every instruction decode accepts.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        PcReSet;
    logic [31:0] PC;
    logic        flush;
    logic        id_ready;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        pc_stall;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .PcReSet     (PcReSet),
        .PC          (PC),
        .flush       (flush),
        .id_ready    (id_ready),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .pc_stall    (pc_stall),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input logic [31:0] pc);
        PcReSet    = 1'b1;
        PC         = pc;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        check("rst_req",   {31'd0, imem_req},  32'd0);
        check("rst_valid", {31'd0, id_valid},  32'd0);
        check("rst_pc",    id_pc,              32'h3000);
        check("rst_instr", id_instr,           32'd0);
        check("rst_err",   {31'd0, fetch_err}, 32'd0);
        sb_q.delete();
        tick();
        tick();
        PcReSet = 1'b0;
    endtask

    // Decode accepts whenever id_valid && id_ready are stable into the next edge.
    always @(negedge clk) begin
        if (PcReSet === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1 && flush === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery actual_pc=%h expected=none at %0t", id_pc, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mon_instr", id_instr,    e.instr);
                check("mon_pc",    id_pc,       e.pc);
                check("mon_plus4", id_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        id_ready = 1'b1;

        // Basic fetch with immediate ack
        do_reset(32'h3000);
        check("s1_idle_stall", {31'd0, pc_stall}, 32'd1);
        tick();
        check("s1_req",  {31'd0, imem_req}, 32'd1);
        check("s1_addr", imem_addr,         32'h3000);
        check("s1_wait_stall", {31'd0, pc_stall}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        push(32'h2008_0005, 32'h3000);
        #1;
        check("s1_ack_stall", {31'd0, pc_stall}, 32'd0);
        tick();
        imem_ack = 1'b0; PC = 32'h3004;
        #1;
        check("s1_post_stall", {31'd0, pc_stall}, 32'd1);
        check("s1_valid", {31'd0, id_valid}, 32'd1);
        check("s1_instr", id_instr,    32'h2008_0005);
        check("s1_pc",    id_pc,       32'h3000);
        check("s1_plus4", id_pc_plus4, 32'h3004);
        check("s1_req_drop", {31'd0, imem_req}, 32'd0);
        tick();
        check("s1_next_req",  {31'd0, imem_req}, 32'd1);
        check("s1_next_addr", imem_addr,         32'h3004);

        // Backpressure: second fetch parks in the skid buffer
        id_ready = 1'b0;
        do_reset(32'h3000);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        push(32'h1111_0000, 32'h3000);
        tick();
        imem_ack = 1'b0; PC = 32'h3004;
        tick();
        check("s2_addr2", imem_addr, 32'h3004);
        imem_ack = 1'b1; imem_rdata = 32'h2222_0004;
        push(32'h2222_0004, 32'h3004);
        tick();
        imem_ack = 1'b0; PC = 32'h3008;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_hold_req",   {31'd0, imem_req}, 32'd0);
            check("s2_hold_stall", {31'd0, pc_stall}, 32'd1);
            check("s2_hold_pc",    id_pc,             32'h3000);
        end
        id_ready = 1'b1;
        tick();
        check("s2_skid_pc",  id_pc,              32'h3004);
        check("s2_skid_req", {31'd0, imem_req},  32'd0);
        tick();
        check("s2_resume_req",  {31'd0, imem_req}, 32'd1);
        check("s2_resume_addr", imem_addr,         32'h3008);
        check("s2_drained",     {31'd0, id_valid}, 32'd0);
        id_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h3333_0008;
        tick();
        imem_ack = 1'b0; PC = 32'h300C;
        tick();
        check("s2_wait_valid", {31'd0, id_valid}, 32'd1);

        // Asynchronous reset in the middle of WAIT
        #2;
        PcReSet = 1'b1;
        #1;
        check("s6_req",   {31'd0, imem_req}, 32'd0);
        check("s6_valid", {31'd0, id_valid}, 32'd0);
        check("s6_pc",    id_pc,             32'h3000);
        PC = 32'h3000; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; id_ready = 1'b1;
        tick();
        tick();
        PcReSet = 1'b0;
        #1;
        check("s6_idle_ack_stall", {31'd0, pc_stall}, 32'd1);
        tick();
        check("s6_ack_ignored", {31'd0, id_valid}, 32'd0);
        check("s6_req_issued",  {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h4444_0000;
        push(32'h4444_0000, 32'h3000);
        tick();
        imem_ack = 1'b0;

        // Flush in the first WAIT cycle, late ack is dropped
        do_reset(32'h3000);
        tick();
        flush = 1'b1;
        #1;
        check("s3_flush_stall", {31'd0, pc_stall}, 32'd0);
        tick();
        flush = 1'b0; PC = 32'h4000;
        #1;
        check("s3_after_flush_stall", {31'd0, pc_stall}, 32'd1);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("s3_drop_ack_stall", {31'd0, pc_stall}, 32'd1);
        tick();
        imem_ack = 1'b0;
        check("s3_dropped", {31'd0, id_valid}, 32'd0);
        tick();
        check("s3_new_req",  {31'd0, imem_req}, 32'd1);
        check("s3_new_addr", imem_addr,         32'h4000);
        imem_ack = 1'b1; imem_rdata = 32'h5555_4000;
        push(32'h5555_4000, 32'h4000);
        tick();
        imem_ack = 1'b0; PC = 32'h4004;
        tick();
        check("s3_addr2", imem_addr, 32'h4004);
        imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        #1;
        check("s3_flush_ack_stall", {31'd0, pc_stall}, 32'd0);
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        check("s3_flush_beats_ack", {31'd0, id_valid}, 32'd0);

        // Misaligned PC goes straight to ERR
        do_reset(32'h3002);
        #1;
        check("s4_no_req0", {31'd0, imem_req}, 32'd0);
        tick();
        check("s4_err", {31'd0, fetch_err}, 32'd1);
        PC = 32'h3004;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s4_no_req", {31'd0, imem_req}, 32'd0);
            check("s4_stall",  {31'd0, pc_stall}, 32'd1);
        end
        flush = 1'b1;
        #1;
        check("s4_flush_stall", {31'd0, pc_stall}, 32'd1);
        flush = 1'b0;

        // Memory timeout after 16 WAIT cycles
        do_reset(32'h3000);
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            check("s5_req_held", {31'd0, imem_req},  32'd1);
            check("s5_no_err",   {31'd0, fetch_err}, 32'd0);
        end
        tick();
        check("s5_req_fall", {31'd0, imem_req},  32'd0);
        check("s5_err",      {31'd0, fetch_err}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        #1;
        check("s5_late_ack_stall", {31'd0, pc_stall}, 32'd1);
        tick();
        imem_ack = 1'b0;
        check("s5_late_ack_ignored", {31'd0, id_valid}, 32'd0);
        check("s5_err_sticky",       {31'd0, fetch_err}, 32'd1);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC register unit: takes the current PC, issues a word read to instruction memory over a req/ack handshake, and presents the instruction to decode with valid/ready flow control.
- Returns pc_stall so the PC unit advances only once per accepted fetch.
- Supports redirect flush from branch/jump resolution, a one-entry skid buffer for decode backpressure, and sticky error detection.

Parameters:
- RESET_PC, 32'h0000_3000, reset value of id_pc.
- IMEM_TIMEOUT, 16, maximum WAIT cycles without imem_ack before error (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- PcReSet  in  1  asynchronous, active-high reset.
- PC  in  32  current PC from the PC unit.
- flush  in  1  redirect in progress (branch/jump taken); discard in-flight and buffered fetches.
- id_ready  in  1  decode accepts id_* this cycle.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- imem_req  out  1  read request.
- imem_addr  out  32  word address for the request.
- id_valid  out  1  id_instr/id_pc hold an instruction.
- id_instr  out  32  fetched instruction.
- id_pc  out  32  address of id_instr.
- id_pc_plus4  out  32  id_pc + 4, combinational.
- pc_stall  out  1  high = PC unit must hold PC.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset values (async on PcReSet high): state IDLE, imem_req 0, imem_addr 0, id_valid 0, id_instr 0 (NOP), id_pc RESET_PC, skid empty, drop 0, timeout counter 0, fetch_err 0.
- States: IDLE, WAIT, HOLD, ERR.
- IDLE, PC[1:0] != 0: go to ERR, set fetch_err, no request issued.
- IDLE, otherwise: register imem_addr <= PC, imem_req <= 1, counter <= 0, drop <= 0, go to WAIT.
- WAIT: imem_req and imem_addr stay stable until imem_ack is sampled high. Ack may arrive in the first WAIT cycle (minimum one cycle after req rises).
- WAIT, no ack: increment counter. If counter reaches IMEM_TIMEOUT-1, go to ERR with imem_req 0 and fetch_err 1.
- WAIT, ack, drop set or flush high: discard data, go to IDLE.
- WAIT, ack, output slot free (id_valid 0 or id_ready 1): load id_instr/id_pc from imem_rdata/imem_addr, id_valid 1, go to IDLE.
- WAIT, ack, output slot occupied: write data and address into skid, go to HOLD.
- imem_req drops on the edge that accepts ack.
- HOLD: no request issued.
  - id_ready high: skid moves to id_*, id_valid stays 1, go to IDLE.
  - flush high: clear skid, go to IDLE.
- ERR: imem_req 0, pc_stall 1. Only PcReSet exits; id_* keep draining normally.
- Output register: id_valid clears on the edge where id_ready is high and no new instruction loads. Data holds stable while id_valid && !id_ready.
- flush:
  - Clears id_valid at the next edge.
  - In WAIT with no ack that cycle, sets drop so the later ack is discarded.
  - flush has priority over a simultaneous ack or id_ready load.
- pc_stall (combinational): low when (state WAIT, imem_ack, !drop, !flush), or when flush is high and state is not ERR. High otherwise, including in the ack cycle of a dropped fetch.
- Throughput: best case 1 instruction per 2 cycles (IDLE then WAIT with immediate ack).
- Arithmetic: id_pc_plus4 wraps modulo 2^32. Counter width is $clog2(IMEM_TIMEOUT)+1.
- PcReSet mid-WAIT: request abandoned immediately. A memory ack arriving after reset release while in IDLE is ignored.

Test Plan:
- Release reset with PC=0x3000; ack one cycle after req with 0x2008_0005 -> imem_addr 0x3000, id_valid 1, id_instr 0x2008_0005, id_pc 0x3000, id_pc_plus4 0x3004, pc_stall low exactly one cycle.
- id_ready held 0; two fetches at 0x3000 and 0x3004 -> second held in HOLD, no third imem_req. Raise id_ready -> 0x3000 then 0x3004 delivered in order, then requests resume.
- flush in the first WAIT cycle, ack 3 cycles later -> no id_valid from that ack, pc_stall low only in the flush cycle, next request uses the new PC.
- PC=0x3002 at IDLE -> imem_req never rises, fetch_err 1 next cycle, pc_stall stays 1 until reset.
- No ack for 16 WAIT cycles -> imem_req falls and fetch_err 1 on the 16th edge. A later ack is ignored.
- Assert PcReSet mid-WAIT -> imem_req 0, id_valid 0, id_pc 0x3000 immediately, without waiting for a clock edge.
